assoc_cache_ctrl: RTL and testbench
===================================

Name: assoc_cache_ctrl

Overview:
- Parametrised 2-way set-associative cache controller between the CPU core and the backing memory bus.
- Successor to the team's direct-mapped 128-byte cache. Adds:
  - single-clock synchronous operation
  - valid bits and per-set LRU replacement
  - a request/acknowledge handshake on both sides
  - automatic read-miss refill and write-through to memory
  - a sequential flush

Parameters:
- ADDR_W, 16, CPU and memory address width.
- DATA_W, 8, data width (one word per line).
- INDEX_W, 6, set index bits. SETS = 2**INDEX_W; default capacity is 2×64 = 128 words.
- TAG_W, ADDR_W-INDEX_W, derived; must not be overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cpu_req  in  1  CPU request strobe; sampled only in IDLE.
- cpu_we  in  1  1 = write, 0 = read; sampled with cpu_req.
- cpu_addr  in  ADDR_W  request address; sampled with cpu_req.
- cpu_wdata  in  DATA_W  write data; sampled with cpu_req.
- flush  in  1  invalidate-all request; sampled only in IDLE.
- cpu_rdata  out  DATA_W  read data; valid while cpu_ready=1.
- cpu_ready  out  1  one-cycle completion pulse.
- hit  out  1  lookup result for the completing access; valid while cpu_ready=1, else 0.
- busy  out  1  high in every state except IDLE.
- mem_req  out  1  memory request; held until mem_ack is sampled.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid with mem_ack.
- mem_ack  in  1  memory completion; sampled only while mem_req=1.

Behaviour:
- Address split:
  - index = addr[INDEX_W-1:0]
  - tag = addr[ADDR_W-1:INDEX_W]
- Storage: per way, arrays of data, tag and valid; one LRU bit per set, pointing at the least-recently-used way.
- Reset (async):
  - state → IDLE.
  - All valid and LRU bits → 0.
  - cpu_ready, hit, busy, mem_req, mem_we → 0.
  - cpu_rdata, mem_addr, mem_wdata → 0.
  - Data and tag arrays are not reset.
- All outputs are registered.
- States: IDLE, LOOKUP, REFILL, WRITE_MEM, FLUSH.
- IDLE:
  - flush=1 → FLUSH, clear the flush counter. flush has priority over cpu_req.
  - Else cpu_req=1 → latch we/addr/wdata → LOOKUP.
- LOOKUP (1 cycle): hit when either way is valid with a matching tag (both ways never match).
  - Read hit: cpu_rdata ← way data, hit ← 1, cpu_ready ← 1 for one cycle, LRU ← other way, → IDLE. Latency is cpu_ready high exactly 2 edges after the request edge.
  - Read miss: → REFILL with mem_req=1, mem_we=0, mem_addr=latched addr.
  - Write, hit or miss: if hit, update that way's data and set LRU ← other way. Then → WRITE_MEM with mem_req=1, mem_we=1, mem_addr/mem_wdata from the latched request. Policy is write-through, no write-allocate.
- REFILL: hold mem_req/mem_addr until mem_ack=1. On ack:
  - Victim is the first invalid way (way0 first), else the LRU way.
  - Victim ← mem_rdata, latched tag, valid=1; LRU ← other way.
  - cpu_rdata ← mem_rdata, hit ← 0, cpu_ready pulse, mem_req ← 0, → IDLE.
- WRITE_MEM: on mem_ack: mem_req ← 0, cpu_ready pulse, hit ← lookup result, → IDLE.
- FLUSH:
  - Clears valid and LRU of one set per cycle, counter 0..SETS-1.
  - After the last set → IDLE; no cpu_ready pulse.
  - busy stays high for exactly SETS cycles.
- Edge cases:
  - mem_ack may arrive any number of cycles ≥1 after mem_req rises.
  - mem_ack outside REFILL/WRITE_MEM is ignored.
  - cpu_req and flush while busy=1 are ignored; there is no queueing.
  - rst mid-operation: mem_req drops asynchronously, the transaction is abandoned, all lines become invalid.

Test Plan:
1. Miss then hit:
   - After reset, read 0x1234 → mem_req=1, mem_we=0, mem_addr=0x1234.
   - Ack with 0x5A → cpu_ready, cpu_rdata=0x5A, hit=0.
   - Re-read 0x1234 → cpu_ready 2 edges after the request, hit=1, 0x5A, mem_req never rises.
2. LRU eviction:
   - Fill 0x1234 (way0) and 0x5634 (way1, same set 0x34); re-read 0x1234 (hit).
   - Read 0x9A34 (miss) → evicts 0x5634.
   - Then 0x1234 hits and 0x5634 misses.
3. Write-through:
   - After caching 0x1234, write 0xC3 → mem write 0x1234/0xC3, hit=1; a following read hits with 0xC3.
   - Write 0x2000 (uncached) → mem write, hit=0; a following read of 0x2000 misses.
4. Flush:
   - After filling 0x1234, pulse flush → busy high exactly 64 cycles, cpu_req ignored meanwhile.
   - Then read 0x1234 → miss.
5. Handshake robustness:
   - Delay mem_ack by 5 cycles → mem_req/mem_addr stable throughout, single cpu_ready.
   - Stray mem_ack in IDLE → no state change.
6. Reset mid-refill: assert rst while mem_req=1 → mem_req=0 immediately; after release, read 0x1234 (previously cached) → miss.

Source files
------------

// File: rtl/assoc_cache_ctrl.sv
// -----------------------------------------------------------------------------
// assoc_cache_ctrl
//
// 2-way set-associative cache controller that sits between the CPU core and
// the backing memory bus. It holds one word per line and uses one LRU bit per
// set. Read misses refill the line from memory. Writes go through to memory
// and do not allocate a line. A flush invalidates one set per cycle.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   cpu_req    in   CPU request strobe (sampled in IDLE only)
//   cpu_we     in   1 = write, 0 = read
//   cpu_addr   in   request address  [ADDR_W]
//   cpu_wdata  in   write data       [DATA_W]
//   flush      in   invalidate-all request (sampled in IDLE, wins over cpu_req)
//   cpu_rdata  out  read data, valid while cpu_ready=1
//   cpu_ready  out  one-cycle completion pulse
//   hit        out  lookup result of the completing access, else 0
//   busy       out  high in every state except IDLE
//   mem_req    out  memory request, held until mem_ack
//   mem_we     out  memory write enable
//   mem_addr   out  memory address
//   mem_wdata  out  memory write data
//   mem_rdata  in   memory read data, valid with mem_ack
//   mem_ack    in   memory completion
// -----------------------------------------------------------------------------
module assoc_cache_ctrl #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int INDEX_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              flush,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              hit,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    // The tag is whatever is left of the address above the index; it is
    // derived here so it can never disagree with ADDR_W/INDEX_W.
    localparam int TAG_W = ADDR_W - INDEX_W;
    localparam int SETS  = 1 << INDEX_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_REFILL,
        S_WRITE_MEM,
        S_FLUSH
    } state_t;

    state_t              state_q, state_d;

    // Latched CPU request
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                wr_hit_q, wr_hit_d;
    logic [INDEX_W-1:0]  flush_cnt_q, flush_cnt_d;

    // Registered outputs
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic                cpu_ready_q, cpu_ready_d;
    logic                hit_q, hit_d;
    logic                busy_q, busy_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

    // Line state: valid and LRU are reset, data and tag are not.
    // lru_q[s] names the least-recently-used way of set s.
    logic [SETS-1:0]     valid0_q, valid0_d;
    logic [SETS-1:0]     valid1_q, valid1_d;
    logic [SETS-1:0]     lru_q, lru_d;
    logic [DATA_W-1:0]   data0_q [SETS];
    logic [DATA_W-1:0]   data1_q [SETS];
    logic [TAG_W-1:0]    tag0_q  [SETS];
    logic [TAG_W-1:0]    tag1_q  [SETS];

    // Array write controls produced by the FSM
    logic                arr_we0, arr_we1, arr_tag_we;
    logic [DATA_W-1:0]   arr_data;

    logic [INDEX_W-1:0]  idx;
    logic [TAG_W-1:0]    tag;
    logic                hit0, hit1, victim;

    assign idx  = addr_q[INDEX_W-1:0];
    assign tag  = addr_q[ADDR_W-1:INDEX_W];
    assign hit0 = valid0_q[idx] && (tag0_q[idx] == tag);
    assign hit1 = valid1_q[idx] && (tag1_q[idx] == tag);

    // Refill victim: first invalid way (way0 first), otherwise the LRU way
    assign victim = !valid0_q[idx] ? 1'b0 :
                    !valid1_q[idx] ? 1'b1 : lru_q[idx];

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wr_hit_d    = wr_hit_q;
        flush_cnt_d = flush_cnt_q;
        cpu_rdata_d = cpu_rdata_q;
        cpu_ready_d = 1'b0;
        hit_d       = 1'b0;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        valid0_d    = valid0_q;
        valid1_d    = valid1_q;
        lru_d       = lru_q;
        arr_we0     = 1'b0;
        arr_we1     = 1'b0;
        arr_tag_we  = 1'b0;
        arr_data    = wdata_q;

        unique case (state_q)
            S_IDLE: begin
                if (flush) begin
                    flush_cnt_d = '0;
                    state_d     = S_FLUSH;
                end else if (cpu_req) begin
                    we_d    = cpu_we;
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    state_d = S_LOOKUP;
                end
            end

            S_LOOKUP: begin
                if (!we_q) begin
                    if (hit0 || hit1) begin
                        cpu_rdata_d = hit0 ? data0_q[idx] : data1_q[idx];
                        hit_d       = 1'b1;
                        cpu_ready_d = 1'b1;
                        // Way0 used -> way1 becomes LRU, and vice versa
                        lru_d[idx]  = hit0;
                        state_d     = S_IDLE;
                    end else begin
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = addr_q;
                        state_d    = S_REFILL;
                    end
                end else begin
                    // Write-through without allocation: only a resident line
                    // is updated, memory is always written.
                    if (hit0) begin
                        arr_we0    = 1'b1;
                        lru_d[idx] = 1'b1;
                    end else if (hit1) begin
                        arr_we1    = 1'b1;
                        lru_d[idx] = 1'b0;
                    end
                    wr_hit_d    = hit0 || hit1;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = wdata_q;
                    state_d     = S_WRITE_MEM;
                end
            end

            S_REFILL: begin
                if (mem_ack) begin
                    arr_data   = mem_rdata;
                    arr_tag_we = 1'b1;
                    if (victim) begin
                        arr_we1       = 1'b1;
                        valid1_d[idx] = 1'b1;
                    end else begin
                        arr_we0       = 1'b1;
                        valid0_d[idx] = 1'b1;
                    end
                    lru_d[idx]  = ~victim;
                    cpu_rdata_d = mem_rdata;
                    cpu_ready_d = 1'b1;
                    hit_d       = 1'b0;
                    mem_req_d   = 1'b0;
                    state_d     = S_IDLE;
                end
            end

            S_WRITE_MEM: begin
                if (mem_ack) begin
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    cpu_ready_d = 1'b1;
                    hit_d       = wr_hit_q;
                    state_d     = S_IDLE;
                end
            end

            S_FLUSH: begin
                valid0_d[flush_cnt_q] = 1'b0;
                valid1_d[flush_cnt_q] = 1'b0;
                lru_d[flush_cnt_q]    = 1'b0;
                if (flush_cnt_q == {INDEX_W{1'b1}}) begin
                    state_d = S_IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end

            default: state_d = S_IDLE;
        endcase

        // busy is registered, so it follows the state being entered
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wr_hit_q    <= 1'b0;
            flush_cnt_q <= '0;
            cpu_rdata_q <= '0;
            cpu_ready_q <= 1'b0;
            hit_q       <= 1'b0;
            busy_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            valid0_q    <= '0;
            valid1_q    <= '0;
            lru_q       <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wr_hit_q    <= wr_hit_d;
            flush_cnt_q <= flush_cnt_d;
            cpu_rdata_q <= cpu_rdata_d;
            cpu_ready_q <= cpu_ready_d;
            hit_q       <= hit_d;
            busy_q      <= busy_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            valid0_q    <= valid0_d;
            valid1_q    <= valid1_d;
            lru_q       <= lru_d;
        end
    end

    // Data/tag storage: no reset, validity is carried by valid0_q/valid1_q
    always_ff @(posedge clk) begin
        if (arr_we0) begin
            data0_q[idx] <= arr_data;
            if (arr_tag_we) tag0_q[idx] <= tag;
        end
        if (arr_we1) begin
            data1_q[idx] <= arr_data;
            if (arr_tag_we) tag1_q[idx] <= tag;
        end
    end

    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ready = cpu_ready_q;
    assign hit       = hit_q;
    assign busy      = busy_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for assoc_cache_ctrl. The reference model treats each set as a
// recency-ordered list of at most two resident (tag, data) lines, most recent
// first, backed by a full byte-addressed memory image.
// -----------------------------------------------------------------------------
module tb_assoc_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, flush;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ready, hit, busy;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        mem_ack;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assoc_cache_ctrl #(.ADDR_W(16), .DATA_W(8), .INDEX_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .flush     (flush),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .hit       (hit),
        .busy      (busy),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    // ---------------- reference model ----------------
    logic [7:0] bmem [65536];
    int         m_cnt [64];
    logic [9:0] m_tag [64][2];
    logic [7:0] m_dat [64][2];

    function automatic int m_find(input int s, input logic [9:0] t);
        for (int i = 0; i < m_cnt[s]; i++)
            if (m_tag[s][i] == t) return i;
        return -1;
    endfunction

    // Make entry p of set s the most recently used
    function automatic void m_touch(input int s, input int p);
        logic [9:0] t;
        logic [7:0] d;
        if (p == 1) begin
            t = m_tag[s][1]; d = m_dat[s][1];
            m_tag[s][1] = m_tag[s][0]; m_dat[s][1] = m_dat[s][0];
            m_tag[s][0] = t;           m_dat[s][0] = d;
        end
    endfunction

    // New line becomes most recent; the least recent one falls out if full
    function automatic void m_insert(input int s, input logic [9:0] t, input logic [7:0] d);
        m_tag[s][1] = m_tag[s][0]; m_dat[s][1] = m_dat[s][0];
        m_tag[s][0] = t;           m_dat[s][0] = d;
        if (m_cnt[s] < 2) m_cnt[s]++;
    endfunction

    function automatic void m_clear();
        for (int s = 0; s < 64; s++) m_cnt[s] = 0;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete CPU access with the memory acknowledging after dly wait cycles
    task automatic access(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                          input int dly, output logic got_hit);
        int         s, p;
        logic [9:0] t;
        logic       exp_hit;
        s = int'(addr[5:0]);
        t = addr[15:6];
        p = m_find(s, t);
        exp_hit = (p >= 0);

        cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1;
        tick();
        cpu_req = 1'b0;
        check("busy_in_lookup", 16'(busy), 16'd1);
        check("ready_early", 16'(cpu_ready), 16'd0);
        tick();

        if (!we && exp_hit) begin
            check("rd_hit_ready", 16'(cpu_ready), 16'd1);
            check("rd_hit_flag", 16'(hit), 16'd1);
            check("rd_hit_data", 16'(cpu_rdata), 16'(m_dat[s][p]));
            check("rd_hit_no_memreq", 16'(mem_req), 16'd0);
            check("rd_hit_busy", 16'(busy), 16'd0);
            got_hit = hit;
            m_touch(s, p);
        end else begin
            check("memreq_rise", 16'(mem_req), 16'd1);
            check("mem_we", 16'(mem_we), 16'(we));
            check("mem_addr", mem_addr, addr);
            if (we) check("mem_wdata", 16'(mem_wdata), 16'(wd));
            check("ready_before_ack", 16'(cpu_ready), 16'd0);
            for (int i = 0; i < dly; i++) begin
                tick();
                check("memreq_hold", 16'(mem_req), 16'd1);
                check("memaddr_hold", mem_addr, addr);
                check("ready_while_wait", 16'(cpu_ready), 16'd0);
            end
            mem_rdata = bmem[addr];
            mem_ack   = 1'b1;
            tick();
            mem_ack   = 1'b0;
            mem_rdata = 8'($urandom);
            check("done_ready", 16'(cpu_ready), 16'd1);
            check("done_hit", 16'(hit), 16'(exp_hit));
            check("done_memreq", 16'(mem_req), 16'd0);
            check("done_busy", 16'(busy), 16'd0);
            if (!we) check("refill_data", 16'(cpu_rdata), 16'(bmem[addr]));
            got_hit = hit;
            if (we) begin
                bmem[addr] = wd;
                if (exp_hit) begin
                    m_dat[s][p] = wd;
                    m_touch(s, p);
                end
            end else begin
                m_insert(s, t, bmem[addr]);
            end
        end

        tick();
        check("ready_single_pulse", 16'(cpu_ready), 16'd0);
        check("hit_idle_zero", 16'(hit), 16'd0);
    endtask

    // Flush with cpu_req held high throughout to show it is ignored
    task automatic do_flush();
        int n;
        flush = 1'b1;
        tick();
        flush   = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
        n = 0;
        while (busy && n < 200) begin
            n++;
            check("flush_no_ready", 16'(cpu_ready), 16'd0);
            check("flush_no_memreq", 16'(mem_req), 16'd0);
            tick();
        end
        cpu_req = 1'b0;
        check("flush_busy_cycles", 16'(n), 16'd64);
        tick();
        check("flush_back_idle", 16'(busy), 16'd0);
        m_clear();
    endtask

    logic h;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        for (int a = 0; a < 65536; a++) bmem[a] = 8'($urandom);
        bmem[16'h1234] = 8'h5A;
        m_clear();
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; flush = 0;
        mem_rdata = 0; mem_ack = 0;
        rst = 1'b1;
        repeat (2) tick();

        // Reset state
        check("rst_ready", 16'(cpu_ready), 16'd0);
        check("rst_hit", 16'(hit), 16'd0);
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_memreq", 16'(mem_req), 16'd0);
        check("rst_memwe", 16'(mem_we), 16'd0);
        check("rst_rdata", 16'(cpu_rdata), 16'd0);
        check("rst_memaddr", mem_addr, 16'd0);
        check("rst_memwdata", 16'(mem_wdata), 16'd0);
        rst = 1'b0;
        tick();

        // 1. miss then hit
        access(1'b0, 16'h1234, 8'h00, 0, h);
        check("p1_first_miss", 16'(h), 16'd0);
        check("p1_refill_5a", 16'(cpu_rdata), 16'h5A);
        access(1'b0, 16'h1234, 8'h00, 0, h);
        check("p1_second_hit", 16'(h), 16'd1);

        // 2. LRU eviction in set 0x34
        access(1'b0, 16'h5634, 8'h00, 1, h);
        check("p2_fill_way1", 16'(h), 16'd0);
        access(1'b0, 16'h1234, 8'h00, 0, h);
        check("p2_reread_hit", 16'(h), 16'd1);
        access(1'b0, 16'h9A34, 8'h00, 2, h);
        check("p2_third_miss", 16'(h), 16'd0);
        access(1'b0, 16'h1234, 8'h00, 0, h);
        check("p2_mru_kept", 16'(h), 16'd1);
        access(1'b0, 16'h5634, 8'h00, 0, h);
        check("p2_lru_evicted", 16'(h), 16'd0);

        // 3. write-through
        access(1'b1, 16'h1234, 8'hC3, 0, h);
        check("p3_write_hit", 16'(h), 16'd1);
        access(1'b0, 16'h1234, 8'h00, 0, h);
        check("p3_read_after_write_hit", 16'(h), 16'd1);
        check("p3_read_after_write_data", 16'(cpu_rdata), 16'hC3);
        access(1'b1, 16'h2000, 8'h77, 1, h);
        check("p3_write_miss", 16'(h), 16'd0);
        access(1'b0, 16'h2000, 8'h00, 0, h);
        check("p3_no_allocate", 16'(h), 16'd0);

        // 4. flush
        do_flush();
        access(1'b0, 16'h1234, 8'h00, 0, h);
        check("p4_miss_after_flush", 16'(h), 16'd0);

        // 5. slow ack and stray ack in IDLE
        access(1'b0, 16'h4321, 8'h00, 5, h);
        check("p5_slow_ack_miss", 16'(h), 16'd0);
        mem_ack = 1'b1;
        repeat (3) begin
            tick();
            check("stray_ack_busy", 16'(busy), 16'd0);
            check("stray_ack_ready", 16'(cpu_ready), 16'd0);
            check("stray_ack_memreq", 16'(mem_req), 16'd0);
        end
        mem_ack = 1'b0;
        access(1'b0, 16'h4321, 8'h00, 0, h);
        check("p5_hit_after_stray", 16'(h), 16'd1);

        // 6. reset in the middle of a refill
        access(1'b0, 16'h1234, 8'h00, 0, h);
        check("p6_cached", 16'(h), 16'd1);
        cpu_we = 1'b0; cpu_addr = 16'h2234; cpu_req = 1'b1;
        tick();
        cpu_req = 1'b0;
        tick();
        check("p6_memreq_up", 16'(mem_req), 16'd1);
        tick();
        rst = 1'b1;
        #1;
        check("p6_async_memreq_drop", 16'(mem_req), 16'd0);
        check("p6_async_busy_drop", 16'(busy), 16'd0);
        tick();
        rst = 1'b0;
        m_clear();
        tick();
        access(1'b0, 16'h1234, 8'h00, 0, h);
        check("p6_miss_after_reset", 16'(h), 16'd0);

        // Randomised traffic over a few sets and tags to force conflicts
        for (int k = 0; k < 200; k++) begin
            logic [15:0] a;
            if ($urandom_range(0, 39) == 0) begin
                do_flush();
            end else begin
                a = {8'($urandom_range(0, 3)), 2'b00, 6'($urandom_range(0, 3))};
                access(1'($urandom_range(0, 2) == 0), a, 8'($urandom),
                       int'($urandom_range(0, 3)), h);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
